// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi
//   Multi-channel PWM DAC with double-buffered duty registers. Every channel
//   shares one prescaled period counter, which runs as a sawtooth in
//   edge-aligned mode or as a triangle in center-aligned mode. All channels
//   copy their shadow duty into the active duty together at the period
//   boundary, so duty updates are glitch-free and phase-coherent.
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low holds the counters at zero and forces sout low
//   wr_en        write strobe for the shadow duty register
//   wr_ch        channel index for the write (out-of-range writes are dropped)
//   wr_data      duty value to write
//   sout         registered PWM outputs, one per channel
//   period_start one-cycle pulse after shadow duties load into active
module pwm_dac_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1,
  parameter int CENTER   = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            en,
  input  logic                                            wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                                wr_data,
  output logic [CHANNELS-1:0]                             sout,
  output logic                                            period_start
);

  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam bit CTR = (CENTER != 0);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [DW-1:0]    div_cnt, div_cnt_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  dir_t             dir, dir_n;
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];

  assign tick = en && (div_cnt == DW'(DIV - 1));

  // Next-state for the prescaler and the period counter.
  always_comb begin
    div_cnt_n = div_cnt;
    cnt_n     = cnt;
    dir_n     = dir;
    load      = 1'b0;
    if (!en) begin
      div_cnt_n = '0;
      cnt_n     = '0;
      dir_n     = UP;
    end else begin
      div_cnt_n = tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        // In center mode cnt==0 only ever occurs while heading up, but the
        // direction term keeps the load condition explicit.
        load = (cnt == '0) && (!CTR || dir == UP);
        if (!CTR) begin
          cnt_n = cnt + 1'b1;
        end else if (dir == UP) begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == '1) dir_n = DOWN;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt_n == '0) dir_n = UP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      cnt          <= '0;
      dir          <= UP;
      period_start <= 1'b0;
      sout         <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      div_cnt      <= div_cnt_n;
      cnt          <= cnt_n;
      dir          <= dir_n;
      period_start <= load;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sout[i] <= en & (active[i] > cnt);
        // Non-blocking copy: a write landing on the load edge is not seen
        // here and waits in shadow for the following period.
        if (load) active[i] <= shadow[i];
      end
      if (wr_en && (int'(wr_ch) < CHANNELS)) shadow[wr_ch] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// tb_pwm_dac_multi
//   Three instances run side by side: edge mode W=8 DIV=1, center mode W=4,
//   and edge mode W=8 DIV=3. A shadow-register model tracks the values the
//   bench writes; at each period_start the duties that should have loaded are
//   turned into an expected period record (length, high count per channel),
//   queued, and compared against what is measured over the following period.
module tb_pwm_dac_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] wen;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [2:0] sout_a [3];
  logic       ps_a   [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_dac_multi #(.WIDTH(8), .CHANNELS(3), .DIV(1), .CENTER(0)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wen[0]), .wr_ch(wr_ch),
    .wr_data(wr_data), .sout(sout_a[0]), .period_start(ps_a[0]));

  pwm_dac_multi #(.WIDTH(4), .CHANNELS(3), .DIV(1), .CENTER(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wen[1]), .wr_ch(wr_ch),
    .wr_data(wr_data[3:0]), .sout(sout_a[1]), .period_start(ps_a[1]));

  pwm_dac_multi #(.WIDTH(8), .CHANNELS(3), .DIV(3), .CENTER(0)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wen[2]), .wr_ch(wr_ch),
    .wr_data(wr_data), .sout(sout_a[2]), .period_start(ps_a[2]));

  typedef struct packed {
    int len;
    int h0;
    int h1;
    int h2;
  } rec_t;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int period_of(input int g);
    case (g)
      0:       return 256;
      1:       return 30;
      default: return 768;
    endcase
  endfunction

  // High clocks per period for duty d: edge counts cnt<d once per tick; the
  // triangle visits 0 once and 1..d-1 twice; the prescaler stretches ticks.
  function automatic int exp_hi(input int g, input int d);
    case (g)
      0:       return d;
      1:       return (d == 0) ? 0 : 2 * d - 1;
      default: return 3 * d;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    int   ps_cnt = 0;
    int   len;
    int   hi [3];
    bit   armed;
    rec_t q [$];
    int   m_sh   [3];
    int   m_prev [3];

    // Shadow model; m_prev holds the shadow contents before the latest edge,
    // which is what a load on that edge copies.
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin
          m_sh[i]   = 0;
          m_prev[i] = 0;
        end
      end else begin
        for (int i = 0; i < 3; i++) m_prev[i] = m_sh[i];
        if (wen[gi] && wr_ch < 2'd3)
          m_sh[wr_ch] = (gi == 1) ? int'(wr_data[3:0]) : int'(wr_data);
      end
    end

    initial forever begin
      rec_t r;
      @(negedge clk);
      if (!rst_n || !en) begin
        armed = 0;
        q.delete();
        len = 0;
        for (int i = 0; i < 3; i++) hi[i] = 0;
      end else begin
        len++;
        for (int i = 0; i < 3; i++) hi[i] += int'(sout_a[gi][i]);
        if (ps_a[gi]) begin
          ps_cnt++;
          if (armed && q.size() > 0) begin
            r = q.pop_front();
            check($sformatf("i%0d_len", gi), len, r.len);
            check($sformatf("i%0d_hi0", gi), hi[0], r.h0);
            check($sformatf("i%0d_hi1", gi), hi[1], r.h1);
            check($sformatf("i%0d_hi2", gi), hi[2], r.h2);
          end
          r.len = period_of(gi);
          r.h0  = exp_hi(gi, m_prev[0]);
          r.h1  = exp_hi(gi, m_prev[1]);
          r.h2  = exp_hi(gi, m_prev[2]);
          q.push_back(r);
          armed = 1;
          len   = 0;
          for (int i = 0; i < 3; i++) hi[i] = 0;
        end
      end
    end
  end

  function automatic int get_ps(input int g);
    case (g)
      0:       return g_mon[0].ps_cnt;
      1:       return g_mon[1].ps_cnt;
      default: return g_mon[2].ps_cnt;
    endcase
  endfunction

  // Returns at negedge+1 of the n-th new period_start of instance g.
  task automatic wait_ps(input int g, input int n);
    int start  = get_ps(g);
    int budget = (n + 1) * period_of(g) + 50;
    while (get_ps(g) < start + n && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check($sformatf("wait_ps%0d", g), get_ps(g) - start, n);
  endtask

  task automatic wr(input logic [2:0] which, input logic [1:0] ch, input logic [7:0] d);
    @(posedge clk);
    #2;
    wen     = which;
    wr_ch   = ch;
    wr_data = d;
    @(posedge clk);
    #2;
    wen = '0;
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_sout%0d", tag, g), int'(sout_a[g]), 0);
      check($sformatf("%s_ps%0d", tag, g), int'(ps_a[g]), 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    wen     = '0;
    wr_ch   = '0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Writes while disabled, plus one out-of-range channel to every instance.
    wr(3'b001, 2'd0, 8'd64);
    wr(3'b001, 2'd1, 8'd0);
    wr(3'b001, 2'd2, 8'd255);
    wr(3'b010, 2'd0, 8'd5);
    wr(3'b010, 2'd1, 8'd15);
    wr(3'b010, 2'd2, 8'd1);
    wr(3'b100, 2'd0, 8'd64);
    wr(3'b100, 2'd1, 8'd255);
    wr(3'b100, 2'd2, 8'd10);
    wr(3'b111, 2'd3, 8'd99);

    @(negedge clk);
    #1;
    check_idle("en0");
    check("en0_cnt_e", int'(u_e.cnt), 0);
    check("en0_cnt_c", int'(u_c.cnt), 0);
    check("en0_div_d", int'(u_d.div_cnt), 0);

    @(posedge clk);
    #2;
    en = 1'b1;
    wait_ps(2, 4);

    // Mid-period write: old duty holds until the next load.
    wait_ps(0, 1);
    repeat (100) @(posedge clk);
    #2;
    wen = 3'b001; wr_ch = 2'd0; wr_data = 8'd200;
    @(posedge clk);
    #2;
    wen = '0;
    wait_ps(0, 3);

    // Write sampled on the same edge as the next load of instance 0.
    wait_ps(0, 1);
    repeat (255) @(posedge clk);
    #2;
    wen = 3'b001; wr_ch = 2'd1; wr_data = 8'd128;
    @(posedge clk);
    #2;
    wen = '0;
    wait_ps(0, 3);

    // Reset mid-period: outputs clear at once, restart loads zero duties.
    repeat (77) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_ps(2, 3);

    @(posedge clk);
    #2;
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("dis");
    check("dis_cnt_e", int'(u_e.cnt), 0);
    check("dis_cnt_c", int'(u_c.cnt), 0);
    check("dis_cnt_d", int'(u_d.cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
